// File: rtl/vr_pkg.sv
// Shared types and sizing helpers for the vr_link valid/ready reference link.
package vr_pkg;

  // Default stream width and default gap settings of the link.
  localparam int DW_DEF     = 32;
  localparam int TX_GAP_DEF = 0;
  localparam int RX_GAP_DEF = 1;

  // Transmitter states. The prefix keeps the GAP state name apart from the receiver's.
  typedef enum logic [1:0] {
    TXS_IDLE = 2'd0,
    TXS_SEND = 2'd1,
    TXS_GAP  = 2'd2
  } tx_state_t;

  // Receiver states.
  typedef enum logic [0:0] {
    RXS_WAIT = 1'b0,
    RXS_GAP  = 1'b1
  } rx_state_t;

  // Larger of two integers, used to size a counter shared by both gaps.
  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width of a down-counter that must hold values 0 .. max_gap-1 (never below 1 bit).
  function automatic int gap_cw(input int max_gap);
    int w;
    w = $clog2(max_gap + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Gap-counter width for the default gap settings.
  localparam int GCW_DEF = gap_cw(imax(TX_GAP_DEF, RX_GAP_DEF));

endpackage

// File: rtl/vr_rx_sink.sv
// Receiver: accepts beats with registered ready, latches the last word and
// counts accepted beats. Ready depends only on its own state, never on valid.
module vr_rx_sink
  import vr_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int RX_GAP = RX_GAP_DEF,
  parameter int CW     = 16,
  parameter int GCW    = GCW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid,
  input  logic [DW-1:0] data,
  output logic          ready,
  output logic [DW-1:0] data_show,
  output logic [CW-1:0] beat_cnt
);

  // Counter reload so that ready stays low for exactly RX_GAP cycles.
  localparam logic [GCW-1:0] GAP_LOAD = GCW'((RX_GAP > 0) ? (RX_GAP - 1) : 0);
  localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  rx_state_t      state_r, state_nxt_s;
  logic           ready_r, ready_nxt_s;
  logic [DW-1:0]  show_r, show_nxt_s;
  logic [CW-1:0]  cnt_r, cnt_nxt_s;
  logic [GCW-1:0] gap_r, gap_nxt_s;
  logic           accept_s;

  // Next-state and next-output logic of the receiver FSM.
  always_comb begin
    state_nxt_s = state_r;
    ready_nxt_s = ready_r;
    show_nxt_s  = show_r;
    cnt_nxt_s   = cnt_r;
    gap_nxt_s   = gap_r;
    accept_s    = valid & ready_r;
    case (state_r)
      RXS_WAIT: begin
        if (accept_s) begin
          show_nxt_s = data;
          cnt_nxt_s  = cnt_r + CNT_ONE;
          if (RX_GAP == 0) begin
            ready_nxt_s = 1'b1;
          end else begin
            state_nxt_s = RXS_GAP;
            ready_nxt_s = 1'b0;
            gap_nxt_s   = GAP_LOAD;
          end
        end else begin
          ready_nxt_s = 1'b1;
        end
      end
      RXS_GAP: begin
        if (gap_r == {GCW{1'b0}}) begin
          state_nxt_s = RXS_WAIT;
          ready_nxt_s = 1'b1;
        end else begin
          gap_nxt_s   = gap_r - {{(GCW-1){1'b0}}, 1'b1};
          ready_nxt_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = RXS_WAIT;
        ready_nxt_s = 1'b0;
        gap_nxt_s   = {GCW{1'b0}};
      end
    endcase
  end

  // State, ready, captured word, beat counter and gap-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RXS_WAIT;
      ready_r <= 1'b0;
      show_r  <= {DW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      gap_r   <= {GCW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      ready_r <= ready_nxt_s;
      show_r  <= show_nxt_s;
      cnt_r   <= cnt_nxt_s;
      gap_r   <= gap_nxt_s;
    end
  end

  assign ready     = ready_r;
  assign data_show = show_r;
  assign beat_cnt  = cnt_r;

endmodule

// File: rtl/vr_tx_gen.sv
// Transmitter: presents an incrementing word stream with registered valid.
// Acceptance uses only registered valid and the registered ready of the
// receiver, so there is no combinational ready->valid path.
module vr_tx_gen
  import vr_pkg::*;
#(
  parameter int            DW     = DW_DEF,
  parameter logic [DW-1:0] START  = {DW{1'b0}},
  parameter logic [DW-1:0] STEP   = {{(DW-1){1'b0}}, 1'b1},
  parameter int            TX_GAP = TX_GAP_DEF,
  parameter int            GCW    = GCW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ready,
  output logic [DW-1:0] data,
  output logic          valid
);

  // Counter reload so that valid stays low for exactly TX_GAP cycles.
  localparam logic [GCW-1:0] GAP_LOAD = GCW'((TX_GAP > 0) ? (TX_GAP - 1) : 0);

  tx_state_t      state_r, state_nxt_s;
  logic [DW-1:0]  data_r, data_nxt_s;
  logic           valid_r, valid_nxt_s;
  logic [GCW-1:0] gap_r, gap_nxt_s;
  logic           accept_s;

  // Next-state and next-output logic of the transmitter FSM.
  always_comb begin
    state_nxt_s = state_r;
    data_nxt_s  = data_r;
    valid_nxt_s = valid_r;
    gap_nxt_s   = gap_r;
    accept_s    = valid_r & ready;
    case (state_r)
      TXS_IDLE: begin
        state_nxt_s = TXS_SEND;
        valid_nxt_s = 1'b1;
      end
      TXS_SEND: begin
        if (accept_s) begin
          data_nxt_s = data_r + STEP;
          if (TX_GAP == 0) begin
            valid_nxt_s = 1'b1;
          end else begin
            state_nxt_s = TXS_GAP;
            valid_nxt_s = 1'b0;
            gap_nxt_s   = GAP_LOAD;
          end
        end else begin
          valid_nxt_s = 1'b1;
        end
      end
      TXS_GAP: begin
        if (gap_r == {GCW{1'b0}}) begin
          state_nxt_s = TXS_SEND;
          valid_nxt_s = 1'b1;
        end else begin
          gap_nxt_s   = gap_r - {{(GCW-1){1'b0}}, 1'b1};
          valid_nxt_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = TXS_IDLE;
        valid_nxt_s = 1'b0;
        gap_nxt_s   = {GCW{1'b0}};
      end
    endcase
  end

  // State, data, valid and gap-counter registers; reset discards any in-flight beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= TXS_IDLE;
      data_r  <= START;
      valid_r <= 1'b0;
      gap_r   <= {GCW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      data_r  <= data_nxt_s;
      valid_r <= valid_nxt_s;
      gap_r   <= gap_nxt_s;
    end
  end

  assign data  = data_r;
  assign valid = valid_r;

endmodule

// File: rtl/vr_link.sv
// Self-contained valid/ready reference link: transmitter plus receiver,
// with the bus and the receiver state exported for observation.
module vr_link
  import vr_pkg::*;
#(
  parameter int            DW     = DW_DEF,
  parameter logic [DW-1:0] START  = {DW{1'b0}},
  parameter logic [DW-1:0] STEP   = {{(DW-1){1'b0}}, 1'b1},
  parameter int            TX_GAP = TX_GAP_DEF,
  parameter int            RX_GAP = RX_GAP_DEF,
  parameter int            CW     = 16
) (
  input  logic          clk,
  input  logic          rst,
  output logic [DW-1:0] data,
  output logic          valid,
  output logic          ready,
  output logic [DW-1:0] data_show,
  output logic [CW-1:0] beat_cnt
);

  // One counter width fits both gap counters.
  localparam int GCW = gap_cw(imax(TX_GAP, RX_GAP));

  vr_tx_gen #(
    .DW     (DW),
    .START  (START),
    .STEP   (STEP),
    .TX_GAP (TX_GAP),
    .GCW    (GCW)
  ) u_tx (
    .clk   (clk),
    .rst   (rst),
    .ready (ready),
    .data  (data),
    .valid (valid)
  );

  vr_rx_sink #(
    .DW     (DW),
    .RX_GAP (RX_GAP),
    .CW     (CW),
    .GCW    (GCW)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .data      (data),
    .ready     (ready),
    .data_show (data_show),
    .beat_cnt  (beat_cnt)
  );

endmodule

// File: tb/tb_vr_link.sv
// Directed bench for vr_link: four parameterisations run side by side on a
// shared clock and reset; expected values are hand-derived per edge.
module tb_vr_link;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Clock generator, 10 time units per cycle.
  always #5 clk = ~clk;

  // Default instance (TX_GAP=0, RX_GAP=1).
  logic [31:0] d_data, d_show;
  logic        d_valid, d_ready;
  logic [15:0] d_cnt;
  // Back-to-back instance (TX_GAP=0, RX_GAP=0).
  logic [31:0] f_data, f_show;
  logic        f_valid, f_ready;
  logic [15:0] f_cnt;
  // Transmitter-gap instance (TX_GAP=3, RX_GAP=1).
  logic [31:0] t_data, t_show;
  logic        t_valid, t_ready;
  logic [15:0] t_cnt;
  // Wrap instance (START=FFFF_FFFE, default gaps).
  logic [31:0] w_data, w_show;
  logic        w_valid, w_ready;
  logic [15:0] w_cnt;

  vr_link u_def (
    .clk(clk), .rst(rst), .data(d_data), .valid(d_valid), .ready(d_ready),
    .data_show(d_show), .beat_cnt(d_cnt)
  );

  vr_link #(.TX_GAP(0), .RX_GAP(0)) u_fast (
    .clk(clk), .rst(rst), .data(f_data), .valid(f_valid), .ready(f_ready),
    .data_show(f_show), .beat_cnt(f_cnt)
  );

  vr_link #(.TX_GAP(3), .RX_GAP(1)) u_tx3 (
    .clk(clk), .rst(rst), .data(t_data), .valid(t_valid), .ready(t_ready),
    .data_show(t_show), .beat_cnt(t_cnt)
  );

  vr_link #(.START(32'hFFFF_FFFE)) u_wrap (
    .clk(clk), .rst(rst), .data(w_data), .valid(w_valid), .ready(w_ready),
    .data_show(w_show), .beat_cnt(w_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk5(input string tag,
                      input logic [31:0] data, input logic valid, input logic ready,
                      input logic [31:0] show, input logic [15:0] cnt,
                      input logic [31:0] e_data, input logic e_valid, input logic e_ready,
                      input logic [31:0] e_show, input logic [15:0] e_cnt);
    check({tag, ".data"},      {32'h0, data},  {32'h0, e_data});
    check({tag, ".valid"},     {63'h0, valid}, {63'h0, e_valid});
    check({tag, ".ready"},     {63'h0, ready}, {63'h0, e_ready});
    check({tag, ".data_show"}, {32'h0, show},  {32'h0, e_show});
    check({tag, ".beat_cnt"},  {48'h0, cnt},   {48'h0, e_cnt});
  endtask

  // Advance one cycle and sample 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] wstart;
    logic [31:0] ed, es;
    logic [15:0] ec;
    logic        ev, er;
    int          n, p;
    wstart = 32'hFFFF_FFFE;

    // Reset held for three edges: every output at its reset value.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk5($sformatf("rst%0d.def", i),  d_data, d_valid, d_ready, d_show, d_cnt, 32'h0, 1'b0, 1'b0, 32'h0, 16'h0);
      chk5($sformatf("rst%0d.wrap", i), w_data, w_valid, w_ready, w_show, w_cnt, wstart, 1'b0, 1'b0, 32'h0, 16'h0);
    end
    check("rst.fast.valid", {63'h0, f_valid}, 64'h0);
    check("rst.tx3.ready",  {63'h0, t_ready}, 64'h0);

    // Release reset and follow all four streams edge by edge.
    rst = 1'b0;
    for (int e = 1; e <= 21; e++) begin
      tick();

      // Default and wrap: one beat every 2 cycles, accepted on even edges.
      if (e == 1) begin
        ev = 1'b1; er = 1'b1; ed = 32'h0; es = 32'h0; ec = 16'h0;
      end else begin
        n  = e / 2;
        ev = 1'b1; er = (e % 2 == 1);
        ed = 32'(n); es = 32'(n - 1); ec = 16'(n);
      end
      chk5($sformatf("def.e%0d", e), d_data, d_valid, d_ready, d_show, d_cnt, ed, ev, er, es, ec);
      if (e <= 8) begin
        chk5($sformatf("wrap.e%0d", e), w_data, w_valid, w_ready, w_show, w_cnt,
             wstart + ed, ev, er, (e == 1) ? 32'h0 : (wstart + es), ec);
      end

      // Back-to-back: one beat per cycle from edge 2 on.
      if (e <= 10) begin
        chk5($sformatf("fast.e%0d", e), f_data, f_valid, f_ready, f_show, f_cnt,
             32'(e - 1), 1'b1, 1'b1, (e >= 2) ? 32'(e - 2) : 32'h0, 16'(e - 1));
      end

      // Transmitter gap of 3: beats on edges 2, 6, 10, ...
      if (e == 1) begin
        ev = 1'b1; er = 1'b1; ed = 32'h0; es = 32'h0; ec = 16'h0;
      end else begin
        n  = (e - 2) / 4 + 1;
        p  = (e - 2) % 4;
        ev = (p == 3); er = (p != 0);
        ed = 32'(n); es = 32'(n - 1); ec = 16'(n);
      end
      chk5($sformatf("tx3.e%0d", e), t_data, t_valid, t_ready, t_show, t_cnt, ed, ev, er, es, ec);
    end

    // Edge 21: default link has valid=ready=1 with word 10 pending.
    check("pre_rst.valid", {63'h0, d_valid}, 64'h1);
    check("pre_rst.ready", {63'h0, d_ready}, 64'h1);
    check("pre_rst.cnt",   {48'h0, d_cnt},   64'd10);

    // Reset on a transfer edge: the beat is dropped and all outputs clear.
    rst = 1'b1;
    tick();
    chk5("midrst.def",  d_data, d_valid, d_ready, d_show, d_cnt, 32'h0, 1'b0, 1'b0, 32'h0, 16'h0);
    chk5("midrst.fast", f_data, f_valid, f_ready, f_show, f_cnt, 32'h0, 1'b0, 1'b0, 32'h0, 16'h0);

    // Stream restarts at START with the beat count starting over.
    rst = 1'b0;
    tick();
    chk5("restart.e1", d_data, d_valid, d_ready, d_show, d_cnt, 32'h0, 1'b1, 1'b1, 32'h0, 16'h0);
    tick();
    chk5("restart.e2", d_data, d_valid, d_ready, d_show, d_cnt, 32'h1, 1'b1, 1'b0, 32'h0, 16'h1);
    chk5("restart.fast.e2", f_data, f_valid, f_ready, f_show, f_cnt, 32'h1, 1'b1, 1'b1, 32'h0, 16'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
